// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two request/response masters and the shared slave port.
// Modport master is the arbiter's view; modport slave is the surrounding masters and decode.
interface mem_arbiter_if;
  logic        m0_valid;
  logic        m0_ready;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic        m1_ready;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;

  logic [1:0]  grant;

  modport master (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata,
    output grant
  );

  modport slave (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata,
    input  grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the slave address decode.
// Define MEM_ARBITER_TIMEOUT_EN to force-complete transactions no slave answers.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                resetn,
  mem_arbiter_if.master       bus,
  input  logic                err_clr,
  output logic                timeout_err,
  output logic [31:0]         err_addr
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_last_q, rr_last_d;

  logic        own_valid;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wstrb;
  logic        fire;
  logic        done;
  logic [31:0] rsp_data;

  always_comb begin
    own_valid = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_wstrb = '0;
    unique case (grant_q)
      2'b01: begin
        own_valid = bus.m0_valid;
        own_addr  = bus.m0_addr;
        own_wdata = bus.m0_wdata;
        own_wstrb = bus.m0_wstrb;
      end
      2'b10: begin
        own_valid = bus.m1_valid;
        own_addr  = bus.m1_addr;
        own_wdata = bus.m1_wdata;
        own_wstrb = bus.m1_wstrb;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0] wait_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  // Abort (owner dropped valid) takes precedence over expiry.
  assign fire = (state_q == StBusy) && !bus.s_ready && own_valid &&
                (wait_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (state_q == StIdle) begin
        wait_q <= '0;
      end else if (!bus.s_ready) begin
        wait_q <= wait_q + 16'd1;
      end
      // A fresh timeout beats a concurrent clear and recaptures the address.
      if (fire && (!err_q || err_clr)) begin
        err_q      <= 1'b1;
        err_addr_q <= own_addr;
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

  assign timeout_err = err_q;
  assign err_addr    = err_addr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr | (TIMEOUT_CYCLES == 0);
  assign fire        = 1'b0;
  assign timeout_err = 1'b0;
  assign err_addr    = '0;
`endif

  assign done     = (state_q == StBusy) && (bus.s_ready || fire);
  assign rsp_data = fire ? 32'hFFFF_FFFF : bus.s_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      StIdle: begin
        // On contention rr_last=1 means m1 went last, so m0 wins.
        if (bus.m0_valid && (!bus.m1_valid || rr_last_q)) begin
          grant_d = 2'b01;
          state_d = StBusy;
        end else if (bus.m1_valid) begin
          grant_d = 2'b10;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (done) begin
          rr_last_d = grant_q[1];
          grant_d   = 2'b00;
          state_d   = StIdle;
        end else if (!own_valid) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.s_valid  = (state_q == StBusy);
  assign bus.s_addr   = own_addr;
  assign bus.s_wdata  = own_wdata;
  assign bus.s_wstrb  = own_wstrb;
  assign bus.m0_ready = grant_q[0] && done;
  assign bus.m1_ready = grant_q[1] && done;
  assign bus.m0_rdata = grant_q[0] ? rsp_data : '0;
  assign bus.m1_rdata = grant_q[1] ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (timeout checks when MEM_ARBITER_TIMEOUT_EN).
module tb_mem_arbiter;
  logic        clk;
  logic        resetn;
  logic        err_clr;
  logic        timeout_err;
  logic [31:0] err_addr;
  int          n_total;
  int          n_bad;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .err_clr    (err_clr),
    .timeout_err(timeout_err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.s_ready  = 1'b0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    err_clr = 1'b0;
    idle_inputs();
    do_reset();
    #1;
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_svalid", 32'(bus.s_valid), 32'h0);
    check_eq("rst_swstrb", 32'(bus.s_wstrb), 32'h0);
    check_eq("rst_saddr", bus.s_addr, 32'h0);
    check_eq("rst_m0ready", 32'(bus.m0_ready), 32'h0);
    check_eq("rst_m1ready", 32'(bus.m1_ready), 32'h0);
    check_eq("rst_terr", 32'(timeout_err), 32'h0);
    check_eq("rst_eaddr", err_addr, 32'h0);

    // Single master read, slave answers one cycle after s_valid.
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0010;
    #1 check_eq("rd_grant_n", 32'(bus.grant), 32'h0);
    cyc();
    check_eq("rd_grant_n1", 32'(bus.grant), 32'h1);
    check_eq("rd_svalid", 32'(bus.s_valid), 32'h1);
    check_eq("rd_saddr", bus.s_addr, 32'h0000_0010);
    check_eq("rd_m0ready_n1", 32'(bus.m0_ready), 32'h0);
    cyc();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h1234_5678;
    #1;
    check_eq("rd_m0ready", 32'(bus.m0_ready), 32'h1);
    check_eq("rd_m0rdata", bus.m0_rdata, 32'h1234_5678);
    check_eq("rd_m1ready", 32'(bus.m1_ready), 32'h0);
    check_eq("rd_m1rdata", bus.m1_rdata, 32'h0);
    cyc();
    idle_inputs();
    #1 check_eq("rd_idle_grant", 32'(bus.grant), 32'h0);
    check_eq("rd_idle_svalid", 32'(bus.s_valid), 32'h0);

    // Contention from reset: 01, 00, 10, 00, 01.
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0020;
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0030;
    cyc();
    bus.s_ready = 1'b1;
    #1 check_eq("ct_g0", 32'(bus.grant), 32'h1);
    check_eq("ct_m0ready", 32'(bus.m0_ready), 32'h1);
    check_eq("ct_m1ready0", 32'(bus.m1_ready), 32'h0);
    cyc();
    bus.s_ready = 1'b0;
    #1 check_eq("ct_g1", 32'(bus.grant), 32'h0);
    cyc();
    bus.s_ready = 1'b1;
    #1 check_eq("ct_g2", 32'(bus.grant), 32'h2);
    check_eq("ct_saddr_m1", bus.s_addr, 32'h0000_0030);
    check_eq("ct_m1ready", 32'(bus.m1_ready), 32'h1);
    check_eq("ct_m0ready0", 32'(bus.m0_ready), 32'h0);
    cyc();
    bus.s_ready = 1'b0;
    #1 check_eq("ct_g3", 32'(bus.grant), 32'h0);
    cyc();
    bus.s_ready = 1'b1;
    #1 check_eq("ct_g4", 32'(bus.grant), 32'h1);
    cyc();
    idle_inputs();

    // m1 write mux while m0 idles.
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0100;
    bus.m1_wdata = 32'hCAFE_BABE; bus.m1_wstrb = 4'b0110;
    #1 check_eq("wr_idle_wstrb", 32'(bus.s_wstrb), 32'h0);
    cyc();
    check_eq("wr_grant", 32'(bus.grant), 32'h2);
    check_eq("wr_saddr", bus.s_addr, 32'h0000_0100);
    check_eq("wr_swdata", bus.s_wdata, 32'hCAFE_BABE);
    check_eq("wr_swstrb", 32'(bus.s_wstrb), 32'h6);
    bus.s_ready = 1'b1;
    #1 check_eq("wr_m1ready", 32'(bus.m1_ready), 32'h1);
    cyc();
    idle_inputs();
    #1 check_eq("wr_after_wstrb", 32'(bus.s_wstrb), 32'h0);

    // Reset in BUSY: leave rr_last=0 first so the post-reset m0 win is meaningful.
    bus.m0_valid = 1'b1;
    cyc();
    bus.s_ready = 1'b1;
    cyc();
    idle_inputs();
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0200;
    cyc();
    check_eq("rb_busy_grant", 32'(bus.grant), 32'h2);
    resetn = 1'b0;
    cyc();
    check_eq("rb_svalid", 32'(bus.s_valid), 32'h0);
    check_eq("rb_grant", 32'(bus.grant), 32'h0);
    resetn = 1'b1;
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0040;
    cyc();
    check_eq("rb_contend", 32'(bus.grant), 32'h1);
    bus.s_ready = 1'b1;
    cyc();
    idle_inputs();

    // Abort by m1: rr_last stays 0, so the next contention goes to m1.
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0300;
    cyc();
    cyc();
    bus.m1_valid = 1'b0;
    #1 check_eq("ab_m1ready", 32'(bus.m1_ready), 32'h0);
    cyc();
    check_eq("ab_grant", 32'(bus.grant), 32'h0);
    bus.m0_valid = 1'b1; bus.m1_valid = 1'b1;
    cyc();
    check_eq("ab_contend", 32'(bus.grant), 32'h2);
    bus.s_ready = 1'b1;
    cyc();
    idle_inputs();

`ifdef MEM_ARBITER_TIMEOUT_EN
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0300_0000;
    cyc();
    for (int i = 0; i < 8; i++) begin
      check_eq("to_wait_ready", 32'(bus.m0_ready), 32'h0);
      cyc();
    end
    check_eq("to_m0ready", 32'(bus.m0_ready), 32'h1);
    check_eq("to_m0rdata", bus.m0_rdata, 32'hFFFF_FFFF);
    cyc();
    idle_inputs();
    #1 check_eq("to_terr", 32'(timeout_err), 32'h1);
    check_eq("to_eaddr", err_addr, 32'h0300_0000);
    check_eq("to_grant", 32'(bus.grant), 32'h0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check_eq("to_clr_terr", 32'(timeout_err), 32'h0);
    check_eq("to_clr_eaddr", err_addr, 32'h0);
`else
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0300_0000;
    cyc();
    for (int i = 0; i < 12; i++) cyc();
    check_eq("nt_grant", 32'(bus.grant), 32'h1);
    check_eq("nt_m0ready", 32'(bus.m0_ready), 32'h0);
    check_eq("nt_terr", 32'(timeout_err), 32'h0);
    idle_inputs();
    cyc();
    check_eq("nt_abort", 32'(bus.grant), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master round-robin arbiter that shares the single memory-mapped slave bus (RAM, SPI ROM, ROM config and peripheral decode) between the picorv32 CPU and a second bus master, such as a DMA engine. It sits between the masters and the address decoder, grants one transaction at a time, and holds the grant until the slave completes. Under an optional build feature it also terminates transactions that no slave answers, so an unmapped access cannot hang the system.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for s_ready before forced completion; range 2..65535. Used only with MEM_ARBITER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- m0_valid  input  1  CPU request; held until m0_ready
- m0_ready  output  1  CPU completion pulse
- m0_addr  input  32  CPU address
- m0_wdata  input  32  CPU write data
- m0_wstrb  input  4  CPU byte strobes; 0 means read
- m0_rdata  output  32  CPU read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_*, second master
- s_valid  output  1  request to slave decode
- s_ready  input  1  slave completion
- s_addr  output  32  muxed address
- s_wdata  output  32  muxed write data
- s_wstrb  output  4  muxed strobes; forced 0 when s_valid=0
- s_rdata  input  32  slave read data
- grant  output  2  one-hot owner: bit0=m0, bit1=m1, 00=idle
- err_clr  input  1  clears timeout_err / err_addr
- timeout_err  output  1  sticky timeout flag
- err_addr  output  32  address of the first timed-out transaction

## Operation
- FSM states: IDLE, BUSY.
- IDLE: grant=00, s_valid=0.
  - One master requesting: that master wins.
  - Both requesting: the master not equal to rr_last wins.
  - On a win, register grant and move to BUSY.
- rr_last (1 bit) records the last-granted master. Reset value is 1, so m0 wins the first contention.
- BUSY: s_valid=1. s_addr/s_wdata/s_wstrb come combinationally from the owner.
- Completion (s_ready=1 in BUSY):
  - owner's mN_ready=1 and mN_rdata=s_rdata in the same cycle;
  - rr_last updates to the owner;
  - state returns to IDLE.
- Owner drops valid in BUSY without ready (abort): return to IDLE, no ready pulse, rr_last unchanged.
- s_ready in IDLE is ignored.
- Non-owner mN_ready is always 0. Its mN_rdata is 0.
- Reset mid-transaction: next edge forces IDLE, grant=00, s_valid=0, rr_last=1, timeout_err=0, err_addr=0. Any in-flight transaction is dropped.
- Reset values of all outputs: m0_ready=0, m1_ready=0, s_valid=0, s_wstrb=0, grant=00, timeout_err=0, err_addr=0. Data outputs are 0.

## Timing
- Request seen in IDLE at cycle N gives grant and s_valid at N+1.
- s_ready at cycle M gives mN_ready at M (combinational) and IDLE at M+1.
- Minimum transaction is 2 cycles (grant plus one-cycle slave), followed by at least one IDLE cycle between grants.
- Both masters requesting continuously alternate strictly m0, m1, m0, ...
- ready is combinational from s_ready. There is no registered rdata path.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entering BUSY and increments each BUSY cycle with s_ready=0.
  - When the counter reaches TIMEOUT_CYCLES with s_ready still 0, the arbiter completes the transaction itself: owner ready=1, rdata=32'hFFFF_FFFF, state returns to IDLE, rr_last updates.
  - If timeout_err=0, it sets timeout_err=1 and err_addr=owner address. Later timeouts do not overwrite err_addr.
  - err_clr=1 clears both on the next edge. A timeout in the same cycle as err_clr wins (sets and captures).
  - s_ready and counter expiry in the same cycle: s_ready wins, no error.
- Not defined: no counter. BUSY waits indefinitely. timeout_err and err_addr are tied 0, and err_clr is ignored.

## Test plan
- Single master: m0 reads 0x0000_0010 with slave ready one cycle after s_valid. Expect grant=01 at N+1, m0_ready at N+2 with rdata=slave value, m1 untouched.
- Contention: m0 and m1 request in the same IDLE cycle after reset. Expect m0 served first, then m1, then m0 again when both stay asserted. Grant sequence 01, 00, 10, 00, 01.
- Write mux: m1 writes 0xCAFEBABE, wstrb=0110 to 0x0000_0100 while m0 idles. s_* reflect m1 exactly. s_wstrb=0 in every IDLE cycle.
- Reset in BUSY: assert resetn=0 while the slave stalls. Next edge gives s_valid=0, grant=00. After release, simultaneous requests grant m0.
- Abort: m1 drops valid mid-BUSY. Return to IDLE with no m1_ready, and the next contention still favours per rr_last.
- With MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: m0 reads unmapped 0x0300_0000 with s_ready=0. Expect m0_ready after 8 waiting cycles, rdata=0xFFFFFFFF, timeout_err=1, err_addr=0x0300_0000, cleared by an err_clr pulse.
